// File: rtl/bit_serial_add_arbiter.sv
// Two-requester round-robin front end feeding a one-bit-per-cycle ripple adder.
// A granted operand pair is summed LSB-first over WIDTH cycles; the result is held until the next one.
module bit_serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_id_q, op_id_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_id_q, rsp_id_d;

  logic             grant_valid;
  logic             grant_id;
  logic             sum_bit;
  logic             carry_next;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_id_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;

  // One full-adder slice on the current LSBs of the shifting operands.
  assign sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    // NOTE: every signal is defaulted to its held value first, so no branch can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    op_id_d     = op_id_q;
    last_id_d   = last_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          a_d       = grant_id ? req1_a : req0_a;
          b_d       = grant_id ? req1_b : req0_b;
          op_id_d   = grant_id;
          last_id_d = grant_id;
          carry_d   = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_next;
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // The visible result only changes once the last bit has been folded in.
        if (cnt_q == LAST_BIT) begin
          rsp_sum_d   = {sum_bit, acc_q[WIDTH-1:1]};
          rsp_carry_d = carry_next;
          rsp_id_d    = op_id_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      op_id_q     <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      op_id_q     <= op_id_d;
      last_id_q   <= last_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_bit_serial_add_arbiter.sv
// Bench for bit_serial_add_arbiter: scenario tasks plus a cycle-level reference model
// (operation countdown, round-robin pointer, a+b arithmetic) compared on every falling edge.
module tb_bit_serial_add_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req0_ready;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit_serial_add_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an operation occupies the block for W+1 cycles after acceptance,
  // the last of which presents the result.
  int           m_cnt   = 0;
  bit           m_last  = 1'b1;
  bit           m_rid   = 1'b0;
  logic [W-1:0] m_rsum  = '0;
  bit           m_rc    = 1'b0;
  bit           m_opid  = 1'b0;
  logic [W:0]   m_opres = '0;
  int           m_hs    = -1;
  int           n_rsp_exp = 0;
  int           n_rsp_obs = 0;
  int           mg;
  int           mon_g;
  bit           mon_on = 1'b0;

  function automatic int exp_grant();
    if (rst || m_cnt != 0) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    mg   = exp_grant();
    m_hs = -1;
    if (rst) begin
      m_cnt  = 0;
      m_last = 1'b1;
      m_rid  = 1'b0;
      m_rsum = '0;
      m_rc   = 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        m_rid          = m_opid;
        {m_rc, m_rsum} = m_opres;
        n_rsp_exp++;
      end
    end else if (mg >= 0) begin
      m_hs    = mg;
      m_last  = (mg == 1);
      m_opid  = (mg == 1);
      m_opres = (mg == 1) ? ({1'b0, req1_a} + {1'b0, req1_b})
                          : ({1'b0, req0_a} + {1'b0, req0_b});
      m_cnt   = W + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      mon_g = exp_grant();
      total += 7;
      if (req0_ready !== (mon_g == 0)) begin bad++; $display("FAIL mon_req0_ready cyc=%0d got=%b exp=%b", cyc, req0_ready, mon_g == 0); end
      if (req1_ready !== (mon_g == 1)) begin bad++; $display("FAIL mon_req1_ready cyc=%0d got=%b exp=%b", cyc, req1_ready, mon_g == 1); end
      if (busy !== (m_cnt != 0)) begin bad++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, m_cnt != 0); end
      if (rsp_valid !== (m_cnt == 1)) begin bad++; $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_cnt == 1); end
      if (rsp_id !== m_rid) begin bad++; $display("FAIL mon_rsp_id cyc=%0d got=%b exp=%b", cyc, rsp_id, m_rid); end
      if (rsp_sum !== m_rsum) begin bad++; $display("FAIL mon_rsp_sum cyc=%0d got=%0h exp=%0h", cyc, rsp_sum, m_rsum); end
      if (rsp_carry !== m_rc) begin bad++; $display("FAIL mon_rsp_carry cyc=%0d got=%b exp=%b", cyc, rsp_carry, m_rc); end
      if (rsp_valid === 1'b1) n_rsp_obs++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Serve whatever is pending until the model is idle with no valid raised.
  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!req0_valid && !req1_valid && m_cnt == 0) break;
      tick();
      if (m_hs == 0) req0_valid = 1'b0;
      if (m_hs == 1) req1_valid = 1'b0;
    end
    total++;
    if (i >= 200) begin bad++; $display("FAIL drain_timeout: got=%0d cycles exp<200", i); end
  endtask

  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int acc_wait, output int lat,
                        output logic [W-1:0] s, output logic c, output logic rid);
    acc_wait = -1;
    lat      = -1;
    s        = '0;
    c        = 1'b0;
    rid      = 1'b0;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (m_hs == int'(id)) begin acc_wait = i; break; end
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin lat = i; s = rsp_sum; c = rsp_carry; rid = rsp_id; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4;
    tick(2);
    mon_on = 1'b1;
    total += 7;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got=%b exp=0", rsp_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    if (rsp_sum !== '0) begin bad++; $display("FAIL reset_rsp_sum: got=%0h exp=0", rsp_sum); end
    if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id: got=%b exp=0", rsp_id); end
    if (rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_rsp_carry: got=%b exp=0", rsp_carry); end
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready: got=%b exp=0", req0_ready); end
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready: got=%b exp=0", req1_ready); end
    rst = 1'b0;
    #1;
    total += 2;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL first_tie_req0_ready: got=%b exp=1", req0_ready); end
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL first_tie_req1_ready: got=%b exp=0", req1_ready); end
    drain();
  endtask

  task automatic test_single();
    int acc_wait, lat;
    logic [W-1:0] s;
    logic c, rid;
    logic [W:0] exp;
    exp = (W+1)'(3) + (W+1)'(5);
    run_op(1'b0, 4'd3, 4'd5, acc_wait, lat, s, c, rid);
    total += 6;
    if (acc_wait != 1) begin bad++; $display("FAIL single_accept_wait: got=%0d exp=1", acc_wait); end
    if (lat != W) begin bad++; $display("FAIL single_latency: got=%0d exp=%0d", lat, W); end
    if (s !== exp[W-1:0]) begin bad++; $display("FAIL single_sum: got=%0h exp=%0h", s, exp[W-1:0]); end
    if (c !== exp[W]) begin bad++; $display("FAIL single_carry: got=%b exp=%b", c, exp[W]); end
    if (rid !== 1'b0) begin bad++; $display("FAIL single_id: got=%b exp=0", rid); end
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_done: got=%b exp=1", busy); end
    tick();
    total += 3;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse: got=%b exp=0", rsp_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got=%b exp=0", busy); end
    if (rsp_sum !== exp[W-1:0]) begin bad++; $display("FAIL single_sum_hold: got=%0h exp=%0h", rsp_sum, exp[W-1:0]); end
  endtask

  task automatic test_wrap();
    int acc_wait, lat;
    logic [W-1:0] s, ones;
    logic c, rid;
    logic [W:0] exp;
    ones = '1;
    exp = {1'b0, ones} + (W+1)'(1);
    run_op(1'b1, ones, 4'd1, acc_wait, lat, s, c, rid);
    total += 4;
    if (lat != W) begin bad++; $display("FAIL wrap1_latency: got=%0d exp=%0d", lat, W); end
    if (s !== exp[W-1:0]) begin bad++; $display("FAIL wrap1_sum: got=%0h exp=%0h", s, exp[W-1:0]); end
    if (c !== exp[W]) begin bad++; $display("FAIL wrap1_carry: got=%b exp=%b", c, exp[W]); end
    if (rid !== 1'b1) begin bad++; $display("FAIL wrap1_id: got=%b exp=1", rid); end
    exp = {1'b0, ones} + {1'b0, ones};
    run_op(1'b1, ones, ones, acc_wait, lat, s, c, rid);
    total += 3;
    if (s !== exp[W-1:0]) begin bad++; $display("FAIL wrap2_sum: got=%0h exp=%0h", s, exp[W-1:0]); end
    if (c !== exp[W]) begin bad++; $display("FAIL wrap2_carry: got=%b exp=%b", c, exp[W]); end
    if (rid !== 1'b1) begin bad++; $display("FAIL wrap2_id: got=%b exp=1", rid); end
    drain();
  endtask

  task automatic test_tie();
    int rc[$];
    logic ids[$];
    logic [W-1:0] sums[$];
    logic cs[$];
    logic [W:0] e0, e1;
    e0 = (W+1)'(2) + (W+1)'(2);
    e1 = (W+1)'(7) + (W+1)'(9);
    do_reset();
    req0_a = 4'd2; req0_b = 4'd2; req0_valid = 1'b1;
    req1_a = 4'd7; req1_b = 4'd9; req1_valid = 1'b1;
    for (int i = 0; i < 40 && rc.size() < 2; i++) begin
      tick();
      if (m_hs == 0) req0_valid = 1'b0;
      if (m_hs == 1) req1_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        rc.push_back(cyc); ids.push_back(rsp_id); sums.push_back(rsp_sum); cs.push_back(rsp_carry);
      end
    end
    total++;
    if (rc.size() != 2) begin
      bad++; $display("FAIL tie_rsp_count: got=%0d exp=2", rc.size());
    end else begin
      total += 7;
      if (ids[0] !== 1'b0) begin bad++; $display("FAIL tie_first_id: got=%b exp=0", ids[0]); end
      if (sums[0] !== e0[W-1:0]) begin bad++; $display("FAIL tie_first_sum: got=%0h exp=%0h", sums[0], e0[W-1:0]); end
      if (cs[0] !== e0[W]) begin bad++; $display("FAIL tie_first_carry: got=%b exp=%b", cs[0], e0[W]); end
      if (ids[1] !== 1'b1) begin bad++; $display("FAIL tie_second_id: got=%b exp=1", ids[1]); end
      if (sums[1] !== e1[W-1:0]) begin bad++; $display("FAIL tie_second_sum: got=%0h exp=%0h", sums[1], e1[W-1:0]); end
      if (cs[1] !== e1[W]) begin bad++; $display("FAIL tie_second_carry: got=%b exp=%b", cs[1], e1[W]); end
      if (rc[1] - rc[0] != W + 2) begin bad++; $display("FAIL tie_spacing: got=%0d exp=%0d", rc[1] - rc[0], W + 2); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic ids[$];
    int hs_cnt = 0;
    int both = 0;
    int busy_ready = 0;
    do_reset();
    req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 80 && ids.size() < 4; i++) begin
      if (req0_ready === 1'b1 && req1_ready === 1'b1) both++;
      if (busy === 1'b1 && (req0_ready === 1'b1 || req1_ready === 1'b1)) busy_ready++;
      tick();
      if (m_hs >= 0) begin
        hs_cnt++;
        if (m_hs == 0) begin
          req0_valid = (hs_cnt <= 2); req0_a = W'($urandom); req0_b = W'($urandom);
        end else begin
          req1_valid = (hs_cnt <= 2); req1_a = W'($urandom); req1_b = W'($urandom);
        end
      end
      if (rsp_valid === 1'b1) ids.push_back(rsp_id);
    end
    total += 3;
    if (both != 0) begin bad++; $display("FAIL b2b_both_ready: got=%0d exp=0", both); end
    if (busy_ready != 0) begin bad++; $display("FAIL b2b_ready_while_busy: got=%0d exp=0", busy_ready); end
    if (ids.size() != 4) begin
      bad++; $display("FAIL b2b_rsp_count: got=%0d exp=4", ids.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ids[k] !== k[0]) begin bad++; $display("FAIL b2b_id_seq[%0d]: got=%b exp=%b", k, ids[k], k[0]); end
      end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int acc_wait, lat;
    logic [W-1:0] s;
    logic c, rid;
    int early = 0;
    run_op(1'b1, 4'd5, 4'd6, acc_wait, lat, s, c, rid);
    drain();
    req0_a = 4'd9; req0_b = 4'd3; req0_valid = 1'b1;
    for (int i = 0; i < 20 && m_hs != 0; i++) tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rsp_valid === 1'b1) early++;
    end
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 4'd1; req1_b = 4'd1;
    tick();
    total += 8;
    if (early != 0) begin bad++; $display("FAIL midrst_early_rsp: got=%0d exp=0", early); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_rsp_valid: got=%b exp=0", rsp_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got=%b exp=0", busy); end
    if (rsp_sum !== '0) begin bad++; $display("FAIL midrst_rsp_sum: got=%0h exp=0", rsp_sum); end
    if (rsp_id !== 1'b0) begin bad++; $display("FAIL midrst_rsp_id: got=%b exp=0", rsp_id); end
    if (rsp_carry !== 1'b0) begin bad++; $display("FAIL midrst_rsp_carry: got=%b exp=0", rsp_carry); end
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL midrst_req0_ready_in_rst: got=%b exp=0", req0_ready); end
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL midrst_req1_ready_in_rst: got=%b exp=0", req1_ready); end
    rst = 1'b0;
    #1;
    total += 2;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL midrst_tie_req0: got=%b exp=1", req0_ready); end
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL midrst_tie_req1: got=%b exp=0", req1_ready); end
    drain();
  endtask

  task automatic test_late_request();
    logic [W:0] exp;
    int got = 0;
    exp = (W+1)'(6) + (W+1)'(7);
    req0_a = 4'd4; req0_b = 4'd4; req0_valid = 1'b1;
    for (int i = 0; i < 20 && m_hs != 0; i++) tick();
    req0_valid = 1'b0;
    req1_a = 4'd6; req1_b = 4'd7; req1_valid = 1'b1;
    #1;
    for (int k = 0; k <= W; k++) begin
      total++;
      if (req1_ready !== 1'b0) begin bad++; $display("FAIL late_ready_busy[%0d]: got=%b exp=0", k, req1_ready); end
      tick();
    end
    total++;
    if (req1_ready !== 1'b1) begin bad++; $display("FAIL late_ready_idle: got=%b exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        got = 1;
        total += 3;
        if (rsp_id !== 1'b1) begin bad++; $display("FAIL late_id: got=%b exp=1", rsp_id); end
        if (rsp_sum !== exp[W-1:0]) begin bad++; $display("FAIL late_sum: got=%0h exp=%0h", rsp_sum, exp[W-1:0]); end
        if (rsp_carry !== exp[W]) begin bad++; $display("FAIL late_carry: got=%b exp=%b", rsp_carry, exp[W]); end
      end
    end
    total++;
    if (got != 1) begin bad++; $display("FAIL late_rsp_timeout: got=%0d exp=1", got); end
    drain();
  endtask

  task automatic test_random();
    int base_exp, base_obs;
    base_exp = n_rsp_exp;
    base_obs = n_rsp_obs;
    for (int i = 0; i < 400; i++) begin
      tick();
      rst = 1'b0;
      if (m_hs == 0) req0_valid = 1'b0;
      if (m_hs == 1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(2) == 0) begin
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(2) == 0) begin
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
      end
      if ($urandom_range(60) == 0) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    drain();
    tick(2);
    total++;
    if (n_rsp_obs - base_obs != n_rsp_exp - base_exp) begin
      bad++; $display("FAIL random_rsp_count: got=%0d exp=%0d", n_rsp_obs - base_obs, n_rsp_exp - base_exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_tie();
    test_back_to_back();
    test_mid_reset();
    test_late_request();
    test_random();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_add_arbiter.md
BIT_SERIAL_ADD_ARBITER -- requirements
Module: bit_serial_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid, input, 1 and req1_valid, input, 1: requester n presents an operand pair.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, each input, WIDTH bits: operands of requester n.
REQ-006 The block SHALL have ports req0_ready, output, 1 and req1_ready, output, 1: requester n is granted this cycle.
REQ-007 The block SHALL have port rsp_valid, output, 1: a result is presented this cycle.
REQ-008 The block SHALL have port rsp_id, output, 1: index of the requester owning the result.
REQ-009 The block SHALL have ports rsp_sum, output, WIDTH bits and rsp_carry, output, 1: result sum and carry-out.
REQ-010 The block SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-012 A handshake for requester n SHALL occur on a rising edge where reqn_valid and reqn_ready are both high.
REQ-013 reqn_ready SHALL be combinational, high only in IDLE with rst low and grant equal to n; at most one ready SHALL be high per cycle.
REQ-014 Grant: if only one requester is valid, that requester; if both are valid, the requester other than last_id; if none, no ready asserted.
REQ-015 last_id SHALL update to the granted index on every handshake; no other event SHALL change it except reset.
REQ-016 On a handshake the block SHALL capture both operands and the requester index, clear the carry and bit counter, and enter SHIFT.
REQ-017 In SHIFT, each edge SHALL add one bit pair LSB-first with the stored carry, shift the sum bit into the result register MSB side, and increment the counter.
REQ-018 On the edge processing bit WIDTH-1, the block SHALL enter DONE with rsp_sum = (a+b) mod 2^WIDTH and rsp_carry = bit WIDTH of a+b.
REQ-019 rsp_valid SHALL be high for exactly the one cycle spent in DONE, i.e. following the WIDTH-th edge after the accepting edge; DONE SHALL return to IDLE on the next edge.
REQ-020 rsp_id, rsp_sum and rsp_carry SHALL be valid while rsp_valid is high and SHALL hold their values until the next result is produced.
REQ-021 No request SHALL be accepted in SHIFT or DONE; a new request at the earliest one edge after DONE exits, giving WIDTH+2 cycles per operation.
REQ-022 Requesters SHALL hold valid and operands stable until ready; behaviour on early withdrawal is undefined, and the bench SHALL not drive it.
REQ-023 Sum arithmetic SHALL wrap modulo 2^WIDTH with no saturation; all-ones + all-ones SHALL give sum all-ones-minus-one (LSB 0) and carry 1.

Reset
REQ-024 On any edge with rst high, including mid-SHIFT or in DONE, the block SHALL enter IDLE and discard any in-flight operation without producing a response.
REQ-025 After reset: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0, last_id=1 (so req0 wins the first tie); both readys SHALL be 0 while rst is high.

Verification
REQ-026 WIDTH=4, req0 only, a=3, b=5 -> accepted first IDLE cycle; rsp_valid pulses one cycle 4 edges later with sum=8, carry=0, id=0; busy high from acceptance through DONE.
REQ-027 req1 only, a=15, b=1 -> sum=0, carry=1, id=1; 15+15 -> sum=14, carry=1.
REQ-028 Both valid after reset, req0 (2,2) and req1 (7,9) -> req0 served first (sum=4, carry=0), then req1 (sum=0, carry=1); rsp_valid pulses 6 cycles apart.
REQ-029 Both held valid for 4 operations -> rsp_id sequence 0,1,0,1; readys never high together; no ready in SHIFT or DONE.
REQ-030 rst pulsed 2 edges into SHIFT -> no rsp_valid, busy=0 and outputs at reset values next cycle; after release, a tie is granted to req0.
REQ-031 req1 raises valid while busy -> req1_ready stays 0 until the first IDLE cycle; acceptance happens there and the result is correct.
